serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 98 +++++++++
 tb/tb_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one external 1-bit full adder LSB first,
// one bit per clock, and collects the sum bits and final carry.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  // The adder only ever sees registered state, so start/op_* never reach fa_*.
  assign fa_a  = (state == RUN) & a_sh[0];
  assign fa_b  = (state == RUN) & b_sh[0];
  assign fa_ci = (state == RUN) & carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_q <= cin;
            sum_sh  <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
          carry_q <= fa_co;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          // The last sum bit goes straight into the result, bypassing sum_sh.
          if (cnt == LAST) begin
            sum   <= {fa_s, sum_sh[WIDTH-1:1]};
            cout  <= fa_co;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl; a behavioural full adder closes the fa_* loop.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout, fa_a, fa_b, fa_ci, fa_s, fa_co;
  logic [7:0] sum;

  int vectors = 0;
  int miscompares = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co)
  );

  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Accepts one operation and waits (bounded) for done; returns the cycle
  // count from accept to done and the fa_a/fa_b bit streams.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output logic [7:0] a_seq, output logic [7:0] b_seq);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    a_seq = '0;
    b_seq = '0;
    while (!done && lat < 40) begin
      if (lat <= 8) begin
        a_seq[lat-1] = fa_a;
        b_seq[lat-1] = fa_b;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    vectors++;
    if ({busy, done, cout, fa_a, fa_b, fa_ci} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {busy, done, cout, fa_a, fa_b, fa_ci});
    end
    vectors++;
    if (sum !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_sum: got %h expected 00", sum);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_start_ignored: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [7:0] as, bs;
    run_op(8'h5A, 8'h3C, 1'b0, lat, as, bs);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d expected 9", lat);
    end
    vectors++;
    if ({cout, sum} !== 9'h096) begin
      miscompares++;
      $display("[TB] FAIL basic_result: got %h expected 096", {cout, sum});
    end
    vectors++;
    if (as !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL basic_fa_a_seq: got %h expected 5a", as);
    end
    vectors++;
    if (bs !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL basic_fa_b_seq: got %h expected 3c", bs);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy_at_done: got %b expected 1", busy);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL basic_after_done: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_carry;
    int lat;
    logic [7:0] as, bs;
    run_op(8'hFF, 8'h01, 1'b0, lat, as, bs);
    vectors++;
    if ({cout, sum} !== 9'h100 || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL carry_ff_01: got %h lat %0d expected 100 lat 9", {cout, sum}, lat);
    end
    run_op(8'hFF, 8'hFF, 1'b1, lat, as, bs);
    vectors++;
    if ({cout, sum} !== 9'h1FF || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL carry_ff_ff_1: got %h lat %0d expected 1ff lat 9", {cout, sum}, lat);
    end
  endtask

  task automatic test_hold;
    int lat;
    logic [7:0] as, bs;
    repeat (5) @(negedge clk);
    vectors++;
    if ({cout, sum} !== 9'h1FF) begin
      miscompares++;
      $display("[TB] FAIL hold_result: got %h expected 1ff", {cout, sum});
    end
    run_op(8'h00, 8'h00, 1'b1, lat, as, bs);
    vectors++;
    if ({cout, sum} !== 9'h001 || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL cin_only: got %h lat %0d expected 001 lat 9", {cout, sum}, lat);
    end
  endtask

  task automatic test_ignore_start;
    int dcount = 0;
    int dcycle = -1;
    @(negedge clk);
    op_a = 8'hF0; op_b = 8'h34; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9);
      op_a = 8'hAA; op_b = 8'h55; cin = 1'b1;
      if (done) begin
        dcount++;
        dcycle = k;
      end
    end
    start = 1'b0;
    vectors++;
    if (dcount !== 1 || dcycle !== 9) begin
      miscompares++;
      $display("[TB] FAIL ignore_done_pulses: got %0d at %0d expected 1 at 9", dcount, dcycle);
    end
    vectors++;
    if ({cout, sum} !== 9'h124) begin
      miscompares++;
      $display("[TB] FAIL ignore_result: got %h expected 124", {cout, sum});
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_no_accept: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic [7:0] as, bs;
    @(negedge clk);
    op_a = 8'h77; op_b = 8'h11; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, done, cout, fa_a, fa_b, fa_ci} !== 6'b0 || sum !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_state: got ctrl %b sum %h expected 000000 sum 00",
               {busy, done, cout, fa_a, fa_b, fa_ci}, sum);
    end
    run_op(8'h77, 8'h11, 1'b0, lat, as, bs);
    vectors++;
    if ({cout, sum} !== 9'h088 || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_rerun: got %h lat %0d expected 088 lat 9", {cout, sum}, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [3] = '{8'h5A, 8'h13, 8'hC8};
    logic [7:0] vb [3] = '{8'hA5, 8'h24, 8'h64};
    logic       vc [3] = '{1'b1, 1'b0, 1'b1};
    logic [8:0] ve [3] = '{9'h100, 9'h037, 9'h12D};
    int dcount = 0;
    @(negedge clk);
    op_a = va[0]; op_b = vb[0]; cin = vc[0]; start = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1 || k == 11) begin
        op_a = va[k/10 + 1]; op_b = vb[k/10 + 1]; cin = vc[k/10 + 1];
      end
      if (done) begin
        vectors++;
        if (dcount > 2 || k !== 9 + 10 * dcount || {cout, sum} !== ve[dcount]) begin
          miscompares++;
          $display("[TB] FAIL b2b_op%0d: got %h at cycle %0d expected %h at cycle %0d",
                   dcount, {cout, sum}, k, ve[dcount > 2 ? 2 : dcount], 9 + 10 * dcount);
        end
        dcount++;
      end
      if (k == 29) start = 1'b0;
    end
    vectors++;
    if (dcount !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_count: got %0d expected 3", dcount);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_hold;
    test_ignore_start;
    test_reset_mid_run;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
